bus_uart_tx_periph: RTL and testbench
=====================================

// Module: bus_uart_tx_periph
// PURPOSE
//  Memory-mapped UART transmitter acting as a responder on the CPU data bus (busWe/busAddr/busWData/busRData/ramControl).
//  CPU pushes bytes into a TX FIFO; an FSM serialises them 8N1 on tx at a programmable baud rate.
//  Sits beside the data RAM on the same bus; the top-level read mux selects busRData when the address hits BASE_ADDR.
// PARAMETERS
//  BASE_ADDR     32'h1000_0000  register window base; hit = busAddr[31:4]==BASE_ADDR[31:4]
//  FIFO_DEPTH    8              TX FIFO entries (power of 2, >=2)
//  DEFAULT_DIV   16'd867        reset value of BAUDDIV (bit period = BAUDDIV+1 clk cycles)
// PORTS
//  clk         in   1   system clock, all logic rising-edge
//  reset       in   1   synchronous, active-high reset
//  busWe       in   1   write strobe, qualified by address hit
//  busAddr     in   32  byte address
//  busWData    in   32  write data
//  ramControl  in   3   access width, RV32 funct3 encoding (3'b010 = word)
//  busRData    out  32  read data, combinational from registers; 0 when no hit
//  tx          out  1   serial output, registered, idle high
//  irq_empty   out  1   registered, high while FIFO empty and FSM IDLE
// BEHAVIOUR
//  Registers (offset): 0x0 TXDATA (W) push busWData[7:0], any width; reads 0.
//   0x4 STATUS (R/W1C): [0] full [1] empty [2] busy(FSM!=IDLE) [3] overflow (sticky) [7:4] count; write 1 to [3] clears it.
//   0x8 BAUDDIV (R/W) [15:0]; write honoured only if ramControl==3'b010, else ignored. 0xC reserved, reads 0.
//  Reads have no side effects. Writes take effect at the clk edge where busWe && hit.
//  Reset: tx=1, irq_empty=1, FIFO empty, overflow=0, BAUDDIV=DEFAULT_DIV, FSM=IDLE, baud counter=0.
//  FIFO: push when full is dropped and sets overflow, even if a pop occurs the same cycle. Pointers wrap mod FIFO_DEPTH.
//  FSM: IDLE -> START when FIFO non-empty: pop byte into shift reg, tx<=0 at same edge (tx falls 1 edge after the push edge).
//   START -> DATA after one bit period; DATA shifts LSB first, 8 bit periods; DATA -> [PARITY] -> STOP (tx=1, one period).
//   STOP -> START directly (back-to-back, no idle gap) if FIFO non-empty at end of stop bit, else IDLE.
//  Bit timing: counter 0..BAUDDIV, bit boundary when counter==BAUDDIV; counter clears on each state entry.
//   BAUDDIV read live: a write mid-frame affects the current bit's compare immediately; if counter already > new value,
//   bit ends when counter wraps at 16'hFFFF (documented hazard; software updates BAUDDIV only while busy=0). BAUDDIV=0 -> 1-cycle bits.
//  Reset asserted mid-frame: frame aborted, tx=1 next edge, FIFO contents discarded.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = even parity (^byte); frame 11 bits; STATUS unchanged.
//  Not defined: no PARITY state, 10-bit 8N1 frame; state encoding must not reserve the parity code.
// STRUCTURE
//  uart_tx_pkg: register offsets (OFF_TXDATA/OFF_STATUS/OFF_BAUDDIV), STATUS bit indices, tx_state_e enum
//   (IDLE, START, DATA, PARITY, STOP), FUNCT3_WORD constant.
//  Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/count, sync active-high reset.
//  Top holds decode, register file, baud counter, FSM and shift register.
// TESTING
//  1 BAUDDIV=3 (word write), write 8'hA5 to TXDATA -> tx low 1 edge later; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high; busy=0 after 40 cycles.
//  2 Write 3 bytes back-to-back -> frames contiguous (stop bit followed directly by start bit); irq_empty rises only after 3rd stop.
//  3 Write FIFO_DEPTH+2 bytes while FSM busy on the first -> STATUS[3]=1, count caps; write 32'h8 to STATUS -> overflow=0.
//  4 Byte write (ramControl=3'b000) to BAUDDIV -> BAUDDIV unchanged; read with busAddr outside window -> busRData=0.
//  5 Assert reset mid-DATA -> next edge tx=1, STATUS reads 32'h0000_0002, BAUDDIV=DEFAULT_DIV.
//  6 With UART_TX_PARITY_EN: send 8'h07 -> parity bit=1, frame 11 bit periods; without: 10 periods.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, bus width code and the transmit FSM state type.
// Build option: UART_TX_PARITY_EN adds the PARITY state (even parity bit).
package uart_tx_pkg;

  // Register offsets inside the 16-byte window
  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  // STATUS bit indices; the FIFO count occupies [ST_COUNT_LO+3:ST_COUNT_LO]
  localparam int ST_FULL     = 0;
  localparam int ST_EMPTY    = 1;
  localparam int ST_BUSY     = 2;
  localparam int ST_OVF      = 3;
  localparam int ST_COUNT_LO = 4;

  // RV32 funct3 code for a full-word access
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;
`else
  // Without parity the encoding holds exactly four states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;
`endif

  // Even parity over one data byte (XOR of all bits)
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with combinational read of the head entry.
// Latency: a pushed entry is visible on pop_data/empty one cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; the caller reads full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Storage array: written only on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bus_uart_tx_periph.sv
// Bus-mapped UART transmitter: CPU pushes bytes to a TX FIFO, FSM sends 8N1 (or 8E1) frames on tx.
// Latency: tx start bit begins one clk edge after the push edge when idle; reads are combinational.
// Backpressure: none on the bus; a push into a full FIFO is dropped and sets sticky overflow.
// Build option: UART_TX_PARITY_EN inserts an even parity bit between data and stop.
module bus_uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [2:0]  ramControl,
  output logic [31:0] busRData,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Address decode
  logic        hit;
  logic [3:0]  off;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_baud;

  // FIFO interface
  logic          push;
  logic          pop;
  logic [7:0]    pop_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_count_next;
  logic [3:0]    count_field;

  // Registers
  logic        overflow;
  logic [15:0] baud_div;

  // Transmit engine
  tx_state_e   state;
  tx_state_e   state_n;
  logic [15:0] baud_cnt;
  logic [15:0] baud_cnt_n;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_n;
  logic        tx_n;
  logic        bit_end;
  logic        busy;

  // Upper write-data bits have no register behind them
  logic        unused_wdata;
  assign unused_wdata = ^busWData[31:16];

  assign hit       = (busAddr[31:4] == BASE_ADDR[31:4]);
  assign off       = busAddr[3:0];
  assign wr_txdata = busWe && hit && (off == OFF_TXDATA);
  assign wr_status = busWe && hit && (off == OFF_STATUS);
  assign wr_baud   = busWe && hit && (off == OFF_BAUDDIV);

  // Full FIFO drops the byte even if the FSM pops in the same cycle
  assign push = wr_txdata && !fifo_full;

  assign busy            = (state != IDLE);
  assign bit_end         = (baud_cnt == baud_div);
  assign count_field     = 4'(fifo_count);
  assign fifo_count_next = fifo_count + CW'(push) - CW'(pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (busWData[7:0]),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow: set by a dropped push, cleared by writing 1 to its STATUS bit
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      overflow <= 1'b1;
    end else if (wr_status && busWData[ST_OVF]) begin
      overflow <= 1'b0;
    end
  end

  // Baud divisor: only full-word writes are honoured
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= DEFAULT_DIV;
    end else if (wr_baud && (ramControl == FUNCT3_WORD)) begin
      baud_div <= busWData[15:0];
    end
  end

  // Combinational read mux; zero outside the window and for write-only/reserved offsets
  always_comb begin
    busRData = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          busRData[ST_FULL]                    = fifo_full;
          busRData[ST_EMPTY]                   = fifo_empty;
          busRData[ST_BUSY]                    = busy;
          busRData[ST_OVF]                     = overflow;
          busRData[ST_COUNT_LO+3:ST_COUNT_LO]  = count_field;
        end
        OFF_BAUDDIV: busRData[15:0] = baud_div;
        default:     busRData = '0;
      endcase
    end
  end

  // FSM state, bit timer, shift register and registered tx line
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      shift_reg <= shift_n;
      bit_idx   <= bit_n;
      tx        <= tx_n;
    end
  end

  // Next-state logic; the timer runs freely and clears on every state entry.
  // The shift register rotates rather than shifts so the byte's parity is preserved.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 16'd1;
    shift_n    = shift_reg;
    bit_n      = bit_idx;
    tx_n       = tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = pop_data;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n    = DATA;
          baud_cnt_n = '0;
          bit_n      = '0;
          tx_n       = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = even_parity(shift_reg);
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {shift_reg[0], shift_reg[7:1]};
            tx_n    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n    = STOP;
          baud_cnt_n = '0;
          tx_n       = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = pop_data;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
      end
    endcase
  end

  // Interrupt reflects the state after this edge: FIFO drained and FSM idle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_empty <= 1'b1;
    end else begin
      irq_empty <= (fifo_count_next == '0) && (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_bus_uart_tx_periph.sv
// Directed bench for bus_uart_tx_periph: register access, frame timing, FIFO and reset.
// A negedge monitor logs tx/irq_empty per cycle; tests compare log entries to hand values.
// Build option: UART_TX_PARITY_EN switches the expected frame to 11 bit periods.
module tb_bus_uart_tx_periph;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [2:0]  ramControl;
  logic [31:0] busRData;
  logic        tx;
  logic        irq_empty;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0          = 0;
  logic tx_log  [4096];
  logic irq_log [4096];

  always #5 clk = ~clk;

  bus_uart_tx_periph dut (
    .clk        (clk),
    .reset      (reset),
    .busWe      (busWe),
    .busAddr    (busAddr),
    .busWData   (busWData),
    .ramControl (ramControl),
    .busRData   (busRData),
    .tx         (tx),
    .irq_empty  (irq_empty)
  );

  // Per-cycle record of the serial line and interrupt, indexed by negedge number
  always @(negedge clk) begin
    if (cyc < 4096) begin
      tx_log[cyc]  = tx;
      irq_log[cyc] = irq_empty;
    end
    cyc = cyc + 1;
  end

  // Expected line level for bit position i of a frame (start, data LSB first, [parity], stop)
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    busWe = 1'b1; busAddr = a; busWData = d; ramControl = f;
    @(negedge clk);
    #1;
    busWe = 1'b0; busAddr = 32'h0; busWData = 32'h0; ramControl = 3'b010;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    #1;
    busAddr = a;
    #1;
    d = busRData;
    busAddr = 32'h0;
  endtask

  task automatic wait_to(input int idx);
    while (cyc - 1 < idx) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1; busWe = 1'b0; busAddr = 32'h0; busWData = 32'h0; ramControl = 3'b010;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
    vectors++; if (irq_empty !== 1'b1) begin miscompares++; $display("FAIL reset_irq: got %b expected 1", irq_empty); end
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL reset_status: got %h expected 00000002", r); end
    bus_read(BASE + 32'h8, r);
    vectors++; if (r !== 32'd867) begin miscompares++; $display("FAIL reset_bauddiv: got %h expected 00000363", r); end
    bus_read(BASE + 32'hC, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL reserved_read: got %h expected 0", r); end
    bus_read(BASE + 32'h0, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL txdata_read: got %h expected 0", r); end
  endtask

  task automatic test_single_frame();
    logic [31:0] r;
    logic [10:0] fr;
    int cw;
    fr = frame_bits(8'hA5);
    bus_write(BASE + 32'h8, 32'd3, 3'b010);
    bus_read(BASE + 32'h8, r);
    vectors++; if (r !== 32'd3) begin miscompares++; $display("FAIL baud_write: got %h expected 3", r); end
    bus_write(BASE + 32'h0, 32'hFFFF_FFA5, 3'b000);
    cw = cyc - 1;
    t0 = cw + 1;
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h6) begin miscompares++; $display("FAIL start_status: got %h expected 00000006", r); end
    vectors++; if (tx_log[cw] !== 1'b1) begin miscompares++; $display("FAIL tx_push_edge: got %b expected 1", tx_log[cw]); end
    vectors++; if (irq_log[cw] !== 1'b0) begin miscompares++; $display("FAIL irq_after_push: got %b expected 0", irq_log[cw]); end
    wait_to(t0 + 4*FB - 2);
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h6) begin miscompares++; $display("FAIL busy_last_cycle: got %h expected 00000006", r); end
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL idle_after_frame: got %h expected 00000002", r); end
    vectors++; if (tx_log[t0] !== 1'b0) begin miscompares++; $display("FAIL start_fall: got %b expected 0", tx_log[t0]); end
    vectors++; if (tx_log[t0+3] !== 1'b0 || tx_log[t0+4] !== 1'b1) begin
      miscompares++; $display("FAIL start_width: got %b%b expected 01", tx_log[t0+3], tx_log[t0+4]);
    end
    for (int b = 0; b < FB; b++) begin
      vectors++;
      if (tx_log[t0+4*b+2] !== fr[b]) begin
        miscompares++; $display("FAIL a5_bit%0d: got %b expected %b", b, tx_log[t0+4*b+2], fr[b]);
      end
    end
    vectors++; if (irq_log[t0+4*FB-1] !== 1'b0 || irq_log[t0+4*FB] !== 1'b1) begin
      miscompares++; $display("FAIL irq_rise: got %b%b expected 01", irq_log[t0+4*FB-1], irq_log[t0+4*FB]);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    logic [10:0] f0, f1, f2;
    int cw;
    int ones;
    f0 = frame_bits(8'h3C); f1 = frame_bits(8'h81); f2 = frame_bits(8'h0F);
    exp = '1;
    exp[FB-1:0]      = f0[FB-1:0];
    exp[2*FB-1:FB]   = f1[FB-1:0];
    exp[3*FB-1:2*FB] = f2[FB-1:0];
    bus_write(BASE, 32'h3C, 3'b000);
    cw = cyc - 1;
    t0 = cw + 1;
    bus_write(BASE, 32'h81, 3'b000);
    bus_write(BASE, 32'h0F, 3'b010);
    wait_to(t0 + 12*FB + 1);
    for (int b = 0; b < 3*FB; b++) begin
      vectors++;
      if (tx_log[t0+4*b+2] !== exp[b]) begin
        miscompares++; $display("FAIL b2b_bit%0d: got %b expected %b", b, tx_log[t0+4*b+2], exp[b]);
      end
    end
    vectors++; if (tx_log[t0+4*FB-1] !== 1'b1 || tx_log[t0+4*FB] !== 1'b0) begin
      miscompares++; $display("FAIL b2b_no_gap: got %b%b expected 10", tx_log[t0+4*FB-1], tx_log[t0+4*FB]);
    end
    ones = 0;
    for (int c = 0; c < 12*FB; c++) if (irq_log[t0+c] !== 1'b0) ones++;
    vectors++; if (ones != 0) begin miscompares++; $display("FAIL b2b_irq_early: got %0d high cycles expected 0", ones); end
    vectors++; if (irq_log[t0+12*FB] !== 1'b1) begin miscompares++; $display("FAIL b2b_irq_end: got %b expected 1", irq_log[t0+12*FB]); end
  endtask

  task automatic test_bauddiv_width();
    logic [31:0] r;
    int c0;
    int zeros;
    bus_write(BASE + 32'h8, 32'h55, 3'b000);
    bus_read(BASE + 32'h8, r);
    vectors++; if (r !== 32'd3) begin miscompares++; $display("FAIL baud_byte_write: got %h expected 3", r); end
    bus_write(BASE + 32'h8, 32'h55, 3'b001);
    bus_read(BASE + 32'h8, r);
    vectors++; if (r !== 32'd3) begin miscompares++; $display("FAIL baud_half_write: got %h expected 3", r); end
    bus_read(32'h1000_0014, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL miss_read_above: got %h expected 0", r); end
    bus_read(32'h0000_0004, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL miss_read_low: got %h expected 0", r); end
    c0 = cyc;
    bus_write(32'h1000_0010, 32'h41, 3'b010);
    bus_write(32'h2000_0000, 32'h41, 3'b010);
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL miss_write_status: got %h expected 00000002", r); end
    wait_to(c0 + 10);
    zeros = 0;
    for (int c = c0; c <= c0 + 10; c++) if (tx_log[c] !== 1'b1) zeros++;
    vectors++; if (zeros != 0) begin miscompares++; $display("FAIL miss_write_tx: got %0d low cycles expected 0", zeros); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int cw;
    bus_write(BASE, 32'h00, 3'b000);
    cw = cyc - 1;
    t0 = cw + 1;
    for (int i = 1; i < 10; i++) bus_write(BASE, 32'(8'h11 * i), 3'b000);
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h8D) begin miscompares++; $display("FAIL overflow_status: got %h expected 0000008d", r); end
    bus_write(BASE + 32'h4, 32'h8, 3'b010);
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h85) begin miscompares++; $display("FAIL overflow_clear: got %h expected 00000085", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    int c0;
    int zeros;
    wait_to(t0 + 25);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL mid_data_tx: got %b expected 0", tx); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_abort_tx: got %b expected 1", tx); end
    vectors++; if (irq_empty !== 1'b1) begin miscompares++; $display("FAIL reset_abort_irq: got %b expected 1", irq_empty); end
    reset = 1'b0;
    c0 = cyc;
    bus_read(BASE + 32'h4, r);
    vectors++; if (r !== 32'h2) begin miscompares++; $display("FAIL reset_abort_status: got %h expected 00000002", r); end
    bus_read(BASE + 32'h8, r);
    vectors++; if (r !== 32'd867) begin miscompares++; $display("FAIL reset_abort_baud: got %h expected 00000363", r); end
    wait_to(c0 + 12);
    zeros = 0;
    for (int c = c0; c <= c0 + 12; c++) if (tx_log[c] !== 1'b1) zeros++;
    vectors++; if (zeros != 0) begin miscompares++; $display("FAIL reset_fifo_flush: got %0d low cycles expected 0", zeros); end
  endtask

  task automatic test_div_zero();
    logic [10:0] fr;
    int cw;
    fr = frame_bits(8'h5A);
    bus_write(BASE + 32'h8, 32'd0, 3'b010);
    bus_write(BASE, 32'h5A, 3'b000);
    cw = cyc - 1;
    t0 = cw + 1;
    wait_to(t0 + FB + 1);
    for (int b = 0; b < FB; b++) begin
      vectors++;
      if (tx_log[t0+b] !== fr[b]) begin
        miscompares++; $display("FAIL div0_bit%0d: got %b expected %b", b, tx_log[t0+b], fr[b]);
      end
    end
    vectors++; if (irq_log[t0+FB-1] !== 1'b0 || irq_log[t0+FB] !== 1'b1) begin
      miscompares++; $display("FAIL div0_len: got %b%b expected 01", irq_log[t0+FB-1], irq_log[t0+FB]);
    end
  endtask

  task automatic test_parity();
    int cw;
    int len;
    bus_write(BASE + 32'h8, 32'd3, 3'b010);
    bus_write(BASE, 32'h07, 3'b000);
    cw = cyc - 1;
    t0 = cw + 1;
`ifdef UART_TX_PARITY_EN
    len = 44;
`else
    len = 40;
`endif
    wait_to(t0 + len + 1);
    vectors++; if (tx_log[t0+38] !== 1'b1) begin miscompares++; $display("FAIL bit9_07: got %b expected 1", tx_log[t0+38]); end
`ifdef UART_TX_PARITY_EN
    vectors++; if (tx_log[t0+42] !== 1'b1) begin miscompares++; $display("FAIL stop_07: got %b expected 1", tx_log[t0+42]); end
`endif
    vectors++; if (tx_log[t0+30] !== 1'b0) begin miscompares++; $display("FAIL bit7_07: got %b expected 0", tx_log[t0+30]); end
    vectors++; if (irq_log[t0+len-1] !== 1'b0 || irq_log[t0+len] !== 1'b1) begin
      miscompares++; $display("FAIL frame_len_07: got %b%b expected 01", irq_log[t0+len-1], irq_log[t0+len]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bauddiv_width();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_div_zero();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
